// File: rtl/cla_serial_adder_ctrl_if.sv
// Valid/ready operand and result bundle for the serial carry-lookahead adder.
// The master drives operands and result acceptance; the slave is the adder itself.
interface cla_serial_adder_ctrl_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, overflow
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, overflow
  );
endinterface

// File: rtl/cla_serial_adder_ctrl.sv
// WIDTH-bit add/subtract built from one 4-bit lookahead slice reused once per nibble,
// least-significant nibble first, with a registered carry between nibbles.
module cla (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is flattened to two logic levels from g, p and cin.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum = p ^ c;
endmodule

module cla_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  cla_serial_adder_ctrl_if.slave  bus
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_width_check
    $error("cla_serial_adder_ctrl: WIDTH must be a multiple of 4 and at least 4");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             a_msb;
  logic             b_msb;
  logic             ready;
  logic             valid;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             ovf;

  logic [3:0]       nib_sum;
  logic             nib_cout;
  logic [WIDTH-1:0] sum_next;

  cla u_cla (
    .a    (a_sh[3:0]),
    .b    (b_sh[3:0]),
    .cin  (carry),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  // The new nibble enters at the top so that after the last nibble the word is in place.
  assign sum_next = WIDTH'({nib_sum, sum_sh} >> 4);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      sum_sh    <= '0;
      cnt       <= '0;
      carry     <= 1'b0;
      a_msb     <= 1'b0;
      b_msb     <= 1'b0;
      ready     <= 1'b1;
      valid     <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh   <= bus.a;
            b_sh   <= bus.sub ? ~bus.b : bus.b;
            carry  <= bus.sub ? 1'b1 : bus.cin;
            cnt    <= '0;
            a_msb  <= bus.a[WIDTH-1];
            b_msb  <= bus.sub ? ~bus.b[WIDTH-1] : bus.b[WIDTH-1];
            ready  <= 1'b0;
            state  <= RUN;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 4;
          b_sh   <= b_sh >> 4;
          sum_sh <= sum_next;
          carry  <= nib_cout;
          cnt    <= cnt + 1'b1;
          // Visible results change only here, so they never show a partial word.
          if (cnt == LAST) begin
            result    <= sum_next;
            carry_out <= nib_cout;
            ovf       <= (a_msb == b_msb) && (sum_next[WIDTH-1] != a_msb);
            valid     <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            valid <= 1'b0;
            ready <= 1'b1;
            state <= IDLE;
          end
        end
        default: begin
          valid <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = valid;
  assign bus.sum       = result;
  assign bus.cout      = carry_out;
  assign bus.overflow  = ovf;
endmodule

// File: tb/tb_cla_serial_adder_ctrl.sv
// Bench for cla_serial_adder_ctrl: directed vectors on a 16-bit instance plus
// randomized regressions on 4, 16 and 32-bit instances against an arithmetic model.
module tb_cla_serial_adder_ctrl;
  logic clk = 1'b0;
  logic rst_dir = 1'b1;
  logic rst_rnd = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   rnd_done = 0;

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs[8];

  cla_serial_adder_ctrl_if #(.WIDTH(16)) dbus ();
  cla_serial_adder_ctrl #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst_dir),
    .bus (dbus)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic markDone();
    rnd_done++;
  endtask

  // Presents one operand set from IDLE and returns edges from accept to out_valid.
  task automatic applyStimulus(input vec_t v, output int lat);
    dbus.a        = v.a;
    dbus.b        = v.b;
    dbus.cin      = v.cin;
    dbus.sub      = v.sub;
    dbus.in_valid = 1'b1;
    dbus.out_ready = 1'b0;
    @(posedge clk); #1;
    dbus.in_valid = 1'b0;
    checkOutput("accept_in_ready_low", dbus.in_ready, 0);
    lat = 0;
    while (!dbus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic releaseResult();
    dbus.out_ready = 1'b1;
    @(posedge clk); #1;
    dbus.out_ready = 1'b0;
  endtask

  initial begin
    vec_t v;
    int   lat;
    int   t;

    vecs[0] = '{16'h1234, 16'h0FCD, 1'b0, 1'b0, 16'h2201, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[6] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[7] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};

    dbus.in_valid  = 1'b0;
    dbus.a         = '0;
    dbus.b         = '0;
    dbus.cin       = 1'b0;
    dbus.sub       = 1'b0;
    dbus.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", dbus.out_valid, 0);
    checkOutput("reset_sum", dbus.sum, 0);
    checkOutput("reset_cout", dbus.cout, 0);
    checkOutput("reset_ovf", dbus.overflow, 0);
    rst_dir = 1'b0;
    rst_rnd = 1'b0;
    @(posedge clk); #1;
    checkOutput("reset_in_ready", dbus.in_ready, 1);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i], lat);
      checkOutput($sformatf("vec%0d_latency", i), lat, 4);
      checkOutput($sformatf("vec%0d_sum", i), dbus.sum, vecs[i].sum);
      checkOutput($sformatf("vec%0d_cout", i), dbus.cout, vecs[i].cout);
      checkOutput($sformatf("vec%0d_ovf", i), dbus.overflow, vecs[i].ovf);
      releaseResult();
      checkOutput($sformatf("vec%0d_in_ready_back", i), dbus.in_ready, 1);
      checkOutput($sformatf("vec%0d_out_valid_low", i), dbus.out_valid, 0);
    end

    // Backpressure: result must hold while new operands are waved at the block.
    v = '{16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0};
    applyStimulus(v, lat);
    checkOutput("bp_latency", lat, 4);
    for (int k = 0; k < 5; k++) begin
      dbus.in_valid = (k % 2 == 0);
      dbus.a = 16'hAAAA;
      dbus.b = 16'h5555;
      @(posedge clk); #1;
      checkOutput("bp_out_valid", dbus.out_valid, 1);
      checkOutput("bp_in_ready", dbus.in_ready, 0);
      checkOutput("bp_sum", dbus.sum, 16'h3333);
      checkOutput("bp_cout", dbus.cout, 0);
    end
    dbus.in_valid = 1'b0;
    releaseResult();
    checkOutput("bp_release_in_ready", dbus.in_ready, 1);
    checkOutput("bp_release_sum_hold", dbus.sum, 16'h3333);
    v = '{16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    applyStimulus(v, lat);
    checkOutput("bp_next_latency", lat, 4);
    checkOutput("bp_next_sum", dbus.sum, 16'h8000);
    checkOutput("bp_next_ovf", dbus.overflow, 1);
    releaseResult();

    // Reset after two nibbles of an op that carries through every nibble.
    dbus.a = 16'hFFFF;
    dbus.b = 16'h0001;
    dbus.cin = 1'b0;
    dbus.sub = 1'b0;
    dbus.in_valid = 1'b1;
    @(posedge clk); #1;
    dbus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_dir = 1'b1;
    #1;
    checkOutput("midrst_sum", dbus.sum, 0);
    checkOutput("midrst_ovf", dbus.overflow, 0);
    checkOutput("midrst_out_valid", dbus.out_valid, 0);
    #2;
    rst_dir = 1'b0;
    @(posedge clk); #1;
    checkOutput("midrst_in_ready", dbus.in_ready, 1);
    checkOutput("midrst_no_result", dbus.out_valid, 0);
    v = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
    applyStimulus(v, lat);
    checkOutput("midrst_next_latency", lat, 4);
    checkOutput("midrst_next_sum", dbus.sum, 16'h0100);
    checkOutput("midrst_next_cout", dbus.cout, 0);
    releaseResult();

    t = 0;
    while (rnd_done < 3 && t < 60000) begin
      @(posedge clk);
      t++;
    end
    checkOutput("rnd_complete", rnd_done, 3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  for (genvar g = 0; g < 3; g++) begin : rnd
    localparam int W = (g == 0) ? 4 : ((g == 1) ? 16 : 32);

    cla_serial_adder_ctrl_if #(.WIDTH(W)) rbus ();
    cla_serial_adder_ctrl #(.WIDTH(W)) rdut (
      .clk (clk),
      .rst (rst_rnd),
      .bus (rbus)
    );

    // Expected values come from integer arithmetic on the operands, not from the nibble datapath.
    initial begin
      logic [W-1:0]    ra;
      logic [W-1:0]    rb;
      logic            rc;
      logic            rs;
      logic [W-1:0]    esum;
      logic            ecout;
      logic            eovf;
      longint unsigned total;
      longint          sa;
      longint          sb;
      longint          sres;
      longint          lmax;
      longint          lmin;
      int              t;
      int              lat;

      lmax = (longint'(1) <<< (W - 1)) - 1;
      lmin = -(longint'(1) <<< (W - 1));
      rbus.in_valid  = 1'b0;
      rbus.a         = '0;
      rbus.b         = '0;
      rbus.cin       = 1'b0;
      rbus.sub       = 1'b0;
      rbus.out_ready = 1'b0;
      wait (rst_rnd == 1'b0);
      @(posedge clk); #1;

      for (int n = 0; n < 1000; n++) begin
        t = $urandom_range(0, 2);
        repeat (t) begin
          @(posedge clk); #1;
        end
        ra = W'($urandom);
        rb = W'($urandom);
        rc = 1'($urandom_range(0, 1));
        rs = 1'($urandom_range(0, 1));
        rbus.a = ra;
        rbus.b = rb;
        rbus.cin = rc;
        rbus.sub = rs;
        rbus.in_valid = 1'b1;
        t = 0;
        while (!rbus.in_ready && t < 50) begin
          @(posedge clk); #1;
          t++;
        end
        @(posedge clk); #1;
        rbus.in_valid = 1'b0;

        if (rs) begin
          esum  = W'(longint'(ra) - longint'(rb));
          ecout = (ra >= rb);
        end else begin
          total = longint'(ra) + longint'(rb) + longint'(rc);
          esum  = W'(total);
          ecout = ((total >> W) != 0);
        end
        sa   = $signed(ra);
        sb   = $signed(rb);
        sres = rs ? (sa - sb) : (sa + sb + longint'(rc));
        eovf = (sres > lmax) || (sres < lmin);

        lat = 0;
        while (!rbus.out_valid && lat < 2 * W) begin
          @(posedge clk); #1;
          lat++;
        end
        checkOutput($sformatf("w%0d_latency", W), lat, W / 4);
        t = 0;
        rbus.out_ready = 1'($urandom_range(0, 1));
        while (!rbus.out_ready && t < 20) begin
          @(posedge clk); #1;
          rbus.out_ready = 1'($urandom_range(0, 1));
          t++;
        end
        rbus.out_ready = 1'b1;
        checkOutput($sformatf("w%0d_sum", W), rbus.sum, esum);
        checkOutput($sformatf("w%0d_cout", W), rbus.cout, ecout);
        checkOutput($sformatf("w%0d_ovf", W), rbus.overflow, eovf);
        @(posedge clk); #1;
        rbus.out_ready = 1'b0;
      end
      markDone();
    end
  end
endmodule

// File: doc/cla_serial_adder_ctrl.md
Name: cla_serial_adder_ctrl

Overview:
Sequencer that performs WIDTH-bit add/subtract by time-multiplexing one 4-bit carry-lookahead slice (module cla, instantiated once inside this block) over WIDTH/4 cycles, least-significant nibble first. A registered carry links the nibbles. Operands enter through a valid/ready handshake and results leave through one. It is the area-minimal alternative to a full-width lookahead adder.

Parameters:
WIDTH, 16, operand/result width; must be a multiple of 4 and >= 4 (elaboration error otherwise)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand request
in_ready  output  1  block can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in (add mode only)
sub  input  1  0 = A+B+cin, 1 = A-B (A + ~B + 1, cin ignored)
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result
cout  output  1  carry out of MSB (sub: 1 = no borrow)
overflow  output  1  two's-complement signed overflow

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high, ports named clk and rst.
- Reset (asserted at any time, including mid-RUN or in DONE): state=IDLE, in_ready=1 once rst deasserts, out_valid=0, sum=0, cout=0, overflow=0, nibble counter=0, carry reg=0. No partial result is ever presented.
- FSM states IDLE, RUN, DONE. in_ready=1 only in IDLE; out_valid=1 only in DONE.
- IDLE: on in_valid&in_ready at an edge, latch the A shift register = a and the B shift register = (sub ? ~b : b). Set carry = (sub ? 1 : cin). Clear counter. Record a[WIDTH-1] and beff[WIDTH-1]. Go to RUN. in_valid while not in IDLE is ignored; it is not queued.
- RUN, one nibble per cycle: cla inputs = A_sh[3:0], B_sh[3:0], carry. At each edge:
  - sum register shifts right by 4 with the cla nibble sum entering at [WIDTH-1:WIDTH-4].
  - A_sh and B_sh shift right by 4.
  - carry = cla cout.
  - counter++.
  - When counter reaches WIDTH/4-1 (last nibble) go to DONE.
- Latency: out_valid rises exactly WIDTH/4 edges after the accepting edge (16-bit: 4 cycles). Throughput is one op per WIDTH/4+2 cycles minimum.
- DONE outputs:
  - sum = full result.
  - cout = final carry.
  - overflow = (a_msb == beff_msb) & (sum[WIDTH-1] != a_msb).
- All outputs hold stable while out_ready=0, for any number of cycles.
- DONE exit: on an out_valid&out_ready edge go to IDLE; in_ready rises the following cycle. sum/cout/overflow keep their last values in IDLE and RUN but are only meaningful while out_valid=1.
- WIDTH=4 edge case: RUN lasts exactly one cycle.
- Counter width is clog2(WIDTH/4), minimum 1 bit; it must not wrap early.
- Carry chain: carry between nibbles is only the registered carry. There is no combinational path from a/b/cin to sum/cout.

Test Plan:
- WIDTH=16, add 0x1234 + 0x0FCD, cin=0 -> sum 0x2201, cout 0, overflow 0. out_valid exactly 4 cycles after accept.
- Add 0xFFFF + 0x0001, cin=0 -> 0x0000, cout 1, ovf 0. Add 0x7FFF + 0x0000, cin=1 -> 0x8000, cout 0, ovf 1 (checks cin propagation through all nibbles).
- Sub 0x0005 - 0x0007 -> 0xFFFE, cout 0, ovf 0. Sub 0x8000 - 0x0001 -> 0x7FFF, cout 1, ovf 1. Sub with cin=1 gives the same results (cin ignored).
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid and outputs stable, in_ready 0, extra in_valid pulses ignored. Release -> in_ready 1 next cycle, then a new op is accepted correctly.
- Reset mid-RUN (after 2 nibbles) -> outputs immediately (asynchronously) zero, state IDLE. Next op 0x00FF + 0x0001 -> 0x0100 with no stale carry.
- Random regression with WIDTH=4, 16 and 32: 1000 ops each, randomized in_valid/out_ready gaps, compared against a behavioural A±B model for sum, cout and overflow.
